mem_io_responder: RTL

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder_pkg.sv | 37 +++
 rtl/io_tx_fifo.sv | 53 +++++
 rtl/mem_io_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants and types for the CPU memory / IO responder.
package mem_io_responder_pkg;

  localparam int ADDR_W  = 32;  // CPU address bus width
  localparam int BYTE_W  = 8;   // data byte width
  localparam int DEC_W   = 18;  // address bits that are actually decoded
  localparam int TIMER_W = 32;  // free-running cycle counter width

  // IO window: any address whose bits 17:16 are 2'b11
  localparam int IO_SEL_HI = 17;
  localparam int IO_SEL_LO = 16;

  localparam logic [DEC_W-1:0] IO_BASE = 18'h30000;
  localparam logic [DEC_W-1:0] IO_UART = 18'h30000;
  localparam logic [DEC_W-1:0] IO_CLK  = 18'h30004;
  localparam logic [1:0]       IO_SEL  = IO_BASE[IO_SEL_HI:IO_SEL_LO];

  // Source of the registered read data presented on mem_din
  typedef enum logic {
    SRC_IO  = 1'b0,
    SRC_RAM = 1'b1
  } rd_src_e;

  // Little-endian byte lane select of a timer word
  function automatic logic [BYTE_W-1:0] word_byte(input logic [TIMER_W-1:0] w,
                                                  input logic [1:0]         idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. Head is shown combinationally;
// a push while full is ignored here (the parent flags the overflow).
module io_tx_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int TX_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [BYTE_W-1:0]             push_data,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(TX_DEPTH):0]     count,
  output logic [BYTE_W-1:0]             head
);

  localparam int PTR_W = $clog2(TX_DEPTH);

  logic [BYTE_W-1:0] store [TX_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == (PTR_W+1)'(TX_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  // Drive zero when empty so the stream bus is quiet while idle
  assign head    = empty ? '0 : store[rd_ptr];

  // Storage array; pointers alone define which entries are live
  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (!push_ok && pop_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Single-cycle CPU memory responder: on-chip byte RAM plus a small IO window
// with a UART TX FIFO, a one-byte UART RX hold, a stop latch and a cycle timer.
// Handshakes (tx_* and rx_*): a byte moves on a rising clk_in edge where
// valid && ready are both high; valid never depends on ready.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH   = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [ADDR_W-1:0] mem_a,
  input  logic [BYTE_W-1:0] mem_dout,
  input  logic              mem_wr,
  output logic [BYTE_W-1:0] mem_din,
  output logic              io_buffer_full,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              program_stop,
  output logic              tx_overflow
);

  localparam int RAM_BYTES = 1 << RAM_ADDR_W;
  localparam int LVL_W     = $clog2(TX_DEPTH) + 1;

  // Address decode
  logic [DEC_W-1:0]      dec_a;
  logic                  is_io;
  logic                  is_ram;
  logic                  hit_uart;
  logic                  hit_clk;
  logic                  clk_win;
  logic [1:0]            byte_sel;
  logic                  unused_addr_hi;

  assign dec_a          = mem_a[DEC_W-1:0];
  assign unused_addr_hi = ^mem_a[ADDR_W-1:DEC_W];
  assign is_io          = (dec_a[IO_SEL_HI:IO_SEL_LO] == IO_SEL);
  assign is_ram         = !is_io && ((dec_a >> RAM_ADDR_W) == '0);
  assign hit_uart       = is_io && (dec_a == IO_UART);
  assign hit_clk        = is_io && (dec_a == IO_CLK);
  assign clk_win        = is_io && (dec_a[DEC_W-1:2] == IO_CLK[DEC_W-1:2]);
  assign byte_sel       = dec_a[1:0];

  // Transaction qualifiers
  logic ram_we;
  logic ram_rd;
  logic uart_rd;
  logic clk_rd;
  logic uart_push;
  logic stop_wr;

  // A write seen on a reset edge is abandoned, so RAM keeps its old byte
  assign ram_we    = !rst_in && mem_wr && is_ram;
  assign ram_rd    = !mem_wr && is_ram;
  assign uart_rd   = !mem_wr && hit_uart;
  assign clk_rd    = !mem_wr && clk_win;
  assign uart_push = mem_wr && hit_uart && (mem_dout != '0);
  assign stop_wr   = mem_wr && hit_clk;

  // RAM: inferred synchronous-read byte array
  logic [BYTE_W-1:0]     ram [RAM_BYTES];
  logic [BYTE_W-1:0]     ram_q;
  logic [RAM_ADDR_W-1:0] ram_idx;

  assign ram_idx = mem_a[RAM_ADDR_W-1:0];

  // Write-then-read of the same byte on later cycles sees the new value
  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_idx] <= mem_dout;
    ram_q <= ram[ram_idx];
  end

  // TX FIFO
  logic              push;
  logic [BYTE_W-1:0] push_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  level;
  logic [LVL_W-1:0]  level_next;
  logic              push_ok;
  logic              pop_ok;

  // The stop write pushes a 0x00 marker, bypassing the zero-byte filter
  assign push      = uart_push || stop_wr;
  assign push_data = stop_wr ? '0 : mem_dout;
  assign tx_valid  = !fifo_empty;
  assign push_ok   = push && !fifo_full;
  assign pop_ok    = tx_valid && tx_ready;

  io_tx_fifo #(
    .TX_DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (push),
    .push_data (push_data),
    .pop       (tx_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (level),
    .head      (tx_data)
  );

  // Occupancy after this edge, used to register the near-full flag
  always_comb begin
    level_next = level;
    if (push_ok && !pop_ok)      level_next = level + 1'b1;
    else if (!push_ok && pop_ok) level_next = level - 1'b1;
  end

  // IO state
  logic [TIMER_W-1:0] cycle_cnt;
  logic [TIMER_W-1:0] snap;
  logic               hold_valid;
  logic [BYTE_W-1:0]  hold_data;
  rd_src_e            rd_src;
  logic [BYTE_W-1:0]  io_q;
  logic [BYTE_W-1:0]  io_rd;

  assign rx_ready = !hold_valid;

  // IO read value; byte 0 of the timer comes live since it is snapshotted now
  always_comb begin
    io_rd = '0;
    if (uart_rd) begin
      io_rd = hold_valid ? hold_data : '0;
    end else if (clk_rd) begin
      io_rd = (byte_sel == 2'd0) ? word_byte(cycle_cnt, 2'd0)
                                 : word_byte(snap, byte_sel);
    end
  end

  // Timer, snapshot, RX hold, sticky flags and read-data source registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cycle_cnt      <= '0;
      snap           <= '0;
      hold_valid     <= 1'b0;
      hold_data      <= '0;
      program_stop   <= 1'b0;
      tx_overflow    <= 1'b0;
      io_buffer_full <= 1'b0;
      rd_src         <= SRC_IO;
      io_q           <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (clk_rd && (byte_sel == 2'd0)) snap <= cycle_cnt;
      if (uart_rd) hold_valid <= 1'b0;
      if (rx_valid && rx_ready) begin
        hold_valid <= 1'b1;
        hold_data  <= rx_data;
      end
      if (stop_wr)              program_stop <= 1'b1;
      if (push && fifo_full)    tx_overflow  <= 1'b1;
      io_buffer_full <= (level_next >= LVL_W'(TX_DEPTH - 2));
      rd_src         <= ram_rd ? SRC_RAM : SRC_IO;
      io_q           <= io_rd;
    end
  end

  assign mem_din = (rd_src == SRC_RAM) ? ram_q : io_q;

endmodule
